// File: rtl/rtc_disp_pkg.sv
// Shared constants and types for the RTC clock/timer VGA display path.
package rtc_disp_pkg;

    localparam int unsigned N_CLOCK_DEF  = 9;
    localparam int unsigned N_TIMER_DEF  = 4;
    localparam int unsigned WAIT_MAX_DEF = 15;
    localparam int unsigned ROW_W_DEF    = 4;

    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;

    localparam logic [3:0] F_CENT   = 4'd0;
    localparam logic [3:0] F_SEC    = 4'd1;
    localparam logic [3:0] F_MIN    = 4'd2;
    localparam logic [3:0] F_HOUR   = 4'd3;
    localparam logic [3:0] F_DATE   = 4'd4;
    localparam logic [3:0] F_MONTH  = 4'd5;
    localparam logic [3:0] F_YEAR   = 4'd6;
    localparam logic [3:0] F_WDAY   = 4'd7;
    localparam logic [3:0] F_WEEK   = 4'd8;
    localparam logic [3:0] F_TCENT  = 4'd9;
    localparam logic [3:0] F_TSEC   = 4'd10;
    localparam logic [3:0] F_TMIN   = 4'd11;
    localparam logic [3:0] F_THOUR  = 4'd12;

    localparam logic [6:0] ASCII_0     = 7'h30;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_DASH  = 7'h2D;
    localparam logic [6:0] ASCII_QMARK = 7'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StNext,
        StSwap
    } cap_state_e;

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD nibble to its ASCII digit code; non-decimal nibbles become '?'.
module bcd_to_ascii
    import rtc_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] char_o
);

    always_comb begin
        if (nibble_i > 4'd9) begin
            char_o = ASCII_QMARK;
        end else begin
            char_o = ASCII_0 + {3'b000, nibble_i};
        end
    end

endmodule

// File: rtl/rtc_frame_capture.sv
// Frame-synchronised RTC field capture into a double-buffered ASCII bank,
// with a registered font-ROM address read port on the display bank.
module rtc_frame_capture
    import rtc_disp_pkg::*;
#(
    parameter int unsigned N_CLOCK  = N_CLOCK_DEF,
    parameter int unsigned N_TIMER  = N_TIMER_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned ROW_W    = ROW_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               timer_en,
    output logic               req_valid,
    output logic [3:0]         req_field,
    input  logic [7:0]         dato_rtc,
    input  logic               dato_valid,
    input  logic [3:0]         rd_field,
    input  logic               rd_digit,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [7+ROW_W-1:0] rd_addr,
    output logic               frame_ok,
    output logic               overrun
);

    localparam int unsigned NF = N_CLOCK + N_TIMER;
    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    // bank[sel][field][digit]: digit 0 = tens, 1 = units
    typedef logic [1:0][NF-1:0][1:0][6:0] bank_t;

    cap_state_e          state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_valid_q, req_valid_d;
    logic [3:0]          req_field_q, req_field_d;
    logic                frame_ok_q, frame_ok_d;
    logic                overrun_q, overrun_d;
    logic                sel_q, sel_d;
    bank_t               bank_q, bank_d;
    logic [7+ROW_W-1:0]  rd_addr_q, rd_addr_d;

    logic       tick;
    logic       shadow;
    logic [6:0] tens_char, units_char;
    logic [6:0] rd_char;

    bcd_to_ascii u_tens (
        .nibble_i (dato_rtc[7:4]),
        .char_o   (tens_char)
    );

    bcd_to_ascii u_units (
        .nibble_i (dato_rtc[3:0]),
        .char_o   (units_char)
    );

    assign tick   = (pixel_x == H_LAST) && (pixel_y == V_LAST);
    assign shadow = ~sel_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        req_valid_d = 1'b0;
        req_field_d = req_field_q;
        frame_ok_d  = 1'b0;
        overrun_d   = overrun_q;
        sel_d       = sel_q;
        bank_d      = bank_q;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    last_d  = timer_en ? 4'(NF - 1) : 4'(N_CLOCK - 1);
                    idx_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                req_valid_d = 1'b1;
                req_field_d = idx_q;
                cnt_d       = '0;
                state_d     = StWait;
            end
            StWait: begin
                if (dato_valid) begin
                    bank_d[shadow][idx_q][0] = tens_char;
                    bank_d[shadow][idx_q][1] = units_char;
                    state_d = StNext;
                end else if (cnt_q == CW'(WAIT_MAX)) begin
                    bank_d[shadow][idx_q][0] = ASCII_DASH;
                    bank_d[shadow][idx_q][1] = ASCII_DASH;
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StNext: begin
                if (idx_q == last_q) begin
                    state_d = StSwap;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StReq;
                end
            end
            StSwap: begin
                // Fields beyond this frame's count (timer off) are blanked
                for (int f = 0; f < int'(NF); f++) begin
                    if (f > int'(last_q)) begin
                        bank_d[shadow][4'(f)][0] = ASCII_SPACE;
                        bank_d[shadow][4'(f)][1] = ASCII_SPACE;
                    end
                end
                if (pixel_y <= V_LAST) begin
                    sel_d      = ~sel_q;
                    frame_ok_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture ran into the next frame: drop it, keep the display bank
        if ((state_q == StReq || state_q == StWait || state_q == StNext) &&
            (pixel_y == 10'd0)) begin
            state_d     = StIdle;
            req_valid_d = 1'b0;
            overrun_d   = 1'b1;
        end
    end

    always_comb begin
        rd_char = ASCII_SPACE;
        if (rd_field < 4'(NF)) begin
            rd_char = bank_q[sel_q][rd_field][rd_digit];
        end
        rd_addr_d = {rd_char, rd_row};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_field_q <= '0;
            frame_ok_q  <= 1'b0;
            overrun_q   <= 1'b0;
            sel_q       <= 1'b0;
            bank_q      <= {(NF * 4){ASCII_SPACE}};
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_field_q <= req_field_d;
            frame_ok_q  <= frame_ok_d;
            overrun_q   <= overrun_d;
            sel_q       <= sel_d;
            bank_q      <= bank_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_field = req_field_q;
    assign frame_ok  = frame_ok_q;
    assign overrun   = overrun_q;
    assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_rtc_frame_capture.sv
// Directed bench for rtc_frame_capture: RTC responder model plus hand-computed
// font addresses for each capture scenario.
module tb_rtc_frame_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        timer_en;
    logic        req_valid;
    logic [3:0]  req_field;
    logic [7:0]  dato_rtc;
    logic        dato_valid;
    logic [3:0]  rd_field;
    logic        rd_digit;
    logic [3:0]  rd_row;
    logic [10:0] rd_addr;
    logic        frame_ok;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Responder table: value per field, and whether the field answers at all
    logic [7:0] resp_val [16];
    logic       resp_en  [16];
    int         req_cnt = 0;
    logic [3:0] seen [256];
    logic       pend = 1'b0;
    logic [3:0] pend_f = '0;

    always #5 clk = ~clk;

    rtc_frame_capture dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .timer_en   (timer_en),
        .req_valid  (req_valid),
        .req_field  (req_field),
        .dato_rtc   (dato_rtc),
        .dato_valid (dato_valid),
        .rd_field   (rd_field),
        .rd_digit   (rd_digit),
        .rd_row     (rd_row),
        .rd_addr    (rd_addr),
        .frame_ok   (frame_ok),
        .overrun    (overrun)
    );

    // Answers one cycle after each req_valid pulse
    initial begin
        dato_valid = 1'b0;
        dato_rtc   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            dato_valid = 1'b0;
            if (pend) begin
                dato_valid = 1'b1;
                dato_rtc   = resp_val[pend_f];
                pend       = 1'b0;
            end
            if (req_valid) begin
                seen[req_cnt[7:0]] = req_field;
                req_cnt = req_cnt + 1;
                if (resp_en[req_field]) begin
                    pend   = 1'b1;
                    pend_f = req_field;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            resp_val[i] = v;
            resp_en[i]  = 1'b1;
        end
    endtask

    task automatic rd_check(input string tag, input logic [3:0] f, input logic d,
                            input logic [3:0] r, input logic [10:0] exp);
        rd_field = f;
        rd_digit = d;
        rd_row   = r;
        step(1);
        check_eq(tag, {21'd0, rd_addr}, {21'd0, exp});
    endtask

    task automatic fire_tick(input logic ten);
        timer_en = ten;
        pixel_x  = 10'd639;
        pixel_y  = 10'd479;
        step(1);
        pixel_x  = 10'd0;
        pixel_y  = 10'd480;
    endtask

    task automatic capture(input string tag, input logic ten, input int exp_reqs);
        int  start;
        int  waited;
        logic got_ok;
        start  = req_cnt;
        waited = 0;
        fire_tick(ten);
        while ((req_cnt - start) < exp_reqs && waited < 400) begin
            step(1);
            waited++;
        end
        step(25);
        check_eq({tag, "_reqs"}, 32'(req_cnt - start), 32'(exp_reqs));
        pixel_y = 10'd10;
        got_ok  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (frame_ok) got_ok = 1'b1;
        end
        check_eq({tag, "_frame_ok"}, {31'd0, got_ok}, 32'd1);
    endtask

    initial begin
        logic seen_ok;
        int   start;
        int   waited;

        reset    = 1'b1;
        pixel_x  = 10'd0;
        pixel_y  = 10'd100;
        timer_en = 1'b0;
        rd_field = 4'd0;
        rd_digit = 1'b0;
        rd_row   = 4'd0;
        set_all(8'h59);
        step(2);
        check_eq("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("rst_req_field", {28'd0, req_field}, 32'd0);
        check_eq("rst_rd_addr", {21'd0, rd_addr}, 32'd0);
        check_eq("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        step(1);
        rd_check("rst_space", 4'd0, 1'b0, 4'd0, 11'h200);

        // Capture A: clock only, every field 0x59
        start = req_cnt;
        capture("capA", 1'b0, 9);
        for (int i = 0; i < 9; i++) begin
            check_eq("capA_req_order", {28'd0, seen[8'(start + i)]}, 32'(i));
        end
        rd_check("capA_sec_tens", 4'd1, 1'b0, 4'd3, 11'h353);
        rd_check("capA_sec_units", 4'd1, 1'b1, 4'd3, 11'h393);
        rd_check("capA_f10_space", 4'd10, 1'b0, 4'd3, 11'h203);
        rd_check("capA_f14_space", 4'd14, 1'b1, 4'd3, 11'h203);
        check_eq("capA_overrun", {31'd0, overrun}, 32'd0);

        // Capture B: timer on, field 12 = 07, field 4 = A3
        set_all(8'h59);
        resp_val[12] = 8'h07;
        resp_val[4]  = 8'hA3;
        capture("capB", 1'b1, 13);
        rd_check("capB_f12_units", 4'd12, 1'b1, 4'd5, 11'h375);
        rd_check("capB_f12_tens", 4'd12, 1'b0, 4'd5, 11'h305);
        rd_check("capB_f4_qmark", 4'd4, 1'b0, 4'd0, 11'h3F0);
        rd_check("capB_f4_units", 4'd4, 1'b1, 4'd0, 11'h330);

        // Capture C: field 2 never answers
        set_all(8'h59);
        resp_en[2] = 1'b0;
        capture("capC", 1'b0, 9);
        rd_check("capC_f2_dash_t", 4'd2, 1'b0, 4'd1, 11'h2D1);
        rd_check("capC_f2_dash_u", 4'd2, 1'b1, 4'd1, 11'h2D1);
        rd_check("capC_f3", 4'd3, 1'b0, 4'd0, 11'h350);

        // Capture D reuses B's bank: timer fields must be blanked
        set_all(8'h12);
        capture("capD", 1'b0, 9);
        rd_check("capD_f12_blank", 4'd12, 1'b1, 4'd5, 11'h205);
        rd_check("capD_f1", 4'd1, 1'b0, 4'd3, 11'h313);
        check_eq("capD_overrun", {31'd0, overrun}, 32'd0);

        // Abort: field 5 stalls and the frame wraps to row 0
        set_all(8'h77);
        resp_en[5] = 1'b0;
        start  = req_cnt;
        waited = 0;
        fire_tick(1'b0);
        while ((req_cnt - start) < 6 && waited < 400) begin
            step(1);
            waited++;
        end
        check_eq("abort_reqs", 32'(req_cnt - start), 32'd6);
        pixel_y = 10'd0;
        step(2);
        pixel_y = 10'd10;
        seen_ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (frame_ok) seen_ok = 1'b1;
        end
        check_eq("abort_no_frame_ok", {31'd0, seen_ok}, 32'd0);
        check_eq("abort_overrun", {31'd0, overrun}, 32'd1);
        check_eq("abort_no_more_reqs", 32'(req_cnt - start), 32'd6);
        rd_check("abort_old_chars", 4'd1, 1'b0, 4'd3, 11'h313);
        step(20);
        check_eq("abort_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset while waiting on field 0
        set_all(8'h59);
        resp_en[0] = 1'b0;
        start  = req_cnt;
        waited = 0;
        fire_tick(1'b0);
        while ((req_cnt - start) < 1 && waited < 50) begin
            step(1);
            waited++;
        end
        step(2);
        reset = 1'b1;
        #1;
        check_eq("rstw_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("rstw_rd_addr", {21'd0, rd_addr}, 32'd0);
        check_eq("rstw_overrun", {31'd0, overrun}, 32'd0);
        step(1);
        reset   = 1'b0;
        pixel_y = 10'd100;
        rd_check("rstw_space", 4'd1, 1'b0, 4'd3, 11'h203);
        set_all(8'h59);
        capture("capE", 1'b0, 9);
        rd_check("capE_sec_tens", 4'd1, 1'b0, 4'd3, 11'h353);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
